// File: rtl/pending_enc_pkg.sv
// Shared constants and FSM state encoding for the pending-request encoder.
// Round-robin selection is enabled by defining PENDING_ENC_ROUND_ROBIN_EN.
package pending_enc_pkg;

    localparam int ENC_WIDTH = 8;
    localparam int ENC_IDX_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

endpackage

// File: rtl/prio_enc8_3.sv
// Combinational lowest-set-bit encoder with a found flag.
// Purely combinational: any rotation for round-robin is applied by the caller.
module prio_enc8_3
    import pending_enc_pkg::*;
#(
    parameter int WIDTH = ENC_WIDTH,
    parameter int IDX_W = ENC_IDX_W
) (
    input  logic [WIDTH-1:0] i_vec,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_found
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_idx   = IDX_W'(i);
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pending_encoder8_3.sv
// Serialises a multi-hot request vector into one binary index per output handshake.
// Define PENDING_ENC_ROUND_ROBIN_EN for rotating selection starting at rr_ptr.
//
// state | meaning
// IDLE  | waiting for a request vector, in_ready=1
// DRAIN | emitting pending indices one per out_ready, in_ready=0
module pending_encoder8_3
    import pending_enc_pkg::*;
#(
    parameter int WIDTH = ENC_WIDTH,
    parameter int IDX_W = ENC_IDX_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_req,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             busy
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_pending;
    logic [WIDTH-1:0] w_pending_nxt;
    logic [WIDTH-1:0] w_enc_vec;
    logic [IDX_W-1:0] w_enc_idx;
    logic [IDX_W-1:0] w_sel_idx;
    logic             w_found;
    logic             w_single;
    logic             w_hs;

    assign w_single = ($countones(r_pending) == 1);
    assign w_hs     = (r_state == DRAIN) && out_ready;

`ifdef PENDING_ENC_ROUND_ROBIN_EN
    logic [IDX_W-1:0] r_rr_ptr;

    // Rotate so rr_ptr lands at bit 0; index arithmetic wraps since WIDTH == 2**IDX_W.
    always_comb begin
        w_enc_vec = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_enc_vec[i] = r_pending[IDX_W'(i) + r_rr_ptr];
        end
    end

    assign w_sel_idx = w_enc_idx + r_rr_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr <= '0;
        end else if (w_hs) begin
            r_rr_ptr <= w_sel_idx + 1'b1;
        end
    end
`else
    assign w_enc_vec = r_pending;
    assign w_sel_idx = w_enc_idx;
`endif

    prio_enc8_3 #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_prio_enc (
        .i_vec   (w_enc_vec),
        .o_idx   (w_enc_idx),
        .o_found (w_found)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_pending <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_pending_nxt;
        end
    end

    // An all-zero vector is accepted and dropped without leaving IDLE.
    always_comb begin
        w_state_nxt   = r_state;
        w_pending_nxt = r_pending;
        case (r_state)
            IDLE: begin
                if (in_valid && (in_req != '0)) begin
                    w_pending_nxt = in_req;
                    w_state_nxt   = DRAIN;
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    w_pending_nxt[w_sel_idx] = 1'b0;
                    if (w_single) begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt   = IDLE;
                w_pending_nxt = '0;
            end
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_idx   = '0;
        out_last  = 1'b0;
        busy      = (r_pending != '0);
        if (r_state == DRAIN) begin
            out_valid = 1'b1;
            out_idx   = w_sel_idx;
            out_last  = w_found && w_single;
        end else begin
            in_ready  = 1'b1;
        end
    end

endmodule

// File: tb/tb_pending_encoder8_3.sv
// Scoreboard bench for pending_encoder8_3; expected indices come from a search model.
// Follows PENDING_ENC_ROUND_ROBIN_EN to pick lowest-first or rotating order.
module tb_pending_encoder8_3;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_req;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_idx;
    logic       out_last;
    logic       busy;

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [3:0] sb[$];
`ifdef PENDING_ENC_ROUND_ROBIN_EN
    int         tb_rr = 0;
`endif

    always #5 clk = ~clk;

    pending_encoder8_3 dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_req    (in_req),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .busy      (busy)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Model: search upward from the start pointer for each set bit, clear it, repeat.
    task automatic push_batch(input logic [7:0] v);
        logic [7:0] p;
        int ptr;
        int idx;
        int j;
        p   = v;
        ptr = 0;
`ifdef PENDING_ENC_ROUND_ROBIN_EN
        ptr = tb_rr;
`endif
        while (p != 8'h00) begin
            idx = -1;
            for (int k = 0; k < 8; k++) begin
                j = (ptr + k) % 8;
                if (idx < 0 && p[j]) idx = j;
            end
            sb.push_back({idx[2:0], ($countones(p) == 1)});
            p[idx] = 1'b0;
`ifdef PENDING_ENC_ROUND_ROBIN_EN
            ptr = (idx + 1) % 8;
`endif
        end
`ifdef PENDING_ENC_ROUND_ROBIN_EN
        tb_rr = ptr;
`endif
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid) begin
            if (sb.size() == 0) begin
                check_val("spurious_valid", out_valid, 0);
            end else begin
                check_val("out_idx", out_idx, sb[0][3:1]);
                check_val("out_last", out_last, sb[0][0]);
                check_val("in_ready_drain", in_ready, 0);
                if (out_ready) void'(sb.pop_front());
            end
        end
    end

    task automatic send(input logic [7:0] v);
        in_valid = 1'b1;
        in_req   = v;
        if (v != 8'h00) push_batch(v);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_req   = 8'h00;
    endtask

    task automatic wait_drain(input bit toggle);
        int cyc;
        cyc = 0;
        while (sb.size() != 0 && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            if (toggle) out_ready = ~out_ready;
        end
        if (sb.size() != 0) begin
            check_val("drain_timeout", sb.size(), 0);
            sb.delete();
        end
        check_val("in_ready_after", in_ready, 1);
        check_val("busy_after", busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_req    = 8'h00;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_val("rst_in_ready", in_ready, 1);
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_out_idx", out_idx, 0);
        check_val("rst_out_last", out_last, 0);
        check_val("rst_busy", busy, 0);

        // Two-bit batch, consumer always ready.
        out_ready = 1'b1;
        send(8'b0010_0100);
        check_val("busy_drain", busy, 1);
        wait_drain(0);

        // Full vector with alternating back-pressure.
        out_ready = 1'b1;
        send(8'hFF);
        wait_drain(1);

        // All-zero vector is dropped.
        send(8'h00);
        check_val("zero_in_ready", in_ready, 1);
        check_val("zero_busy", busy, 0);
        check_val("zero_out_valid", out_valid, 0);
        repeat (3) @(posedge clk);
        #1;
        check_val("zero_out_valid_late", out_valid, 0);

        // New vector offered during DRAIN must be ignored.
        out_ready = 1'b0;
        send(8'h81);
        in_valid = 1'b1;
        in_req   = 8'h02;
        @(posedge clk);
        #1;
        check_val("ignore_in_ready", in_ready, 0);
        in_valid  = 1'b0;
        in_req    = 8'h00;
        out_ready = 1'b1;
        wait_drain(0);
        repeat (3) @(posedge clk);
        #1;
        check_val("ignore_idle_valid", out_valid, 0);

        // Reset in the middle of a batch.
        out_ready = 1'b1;
        send(8'h0F);
        @(posedge clk);
        #1;
        reset = 1'b1;
        sb.delete();
`ifdef PENDING_ENC_ROUND_ROBIN_EN
        tb_rr = 0;
`endif
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_val("midrst_out_valid", out_valid, 0);
        check_val("midrst_busy", busy, 0);
        check_val("midrst_in_ready", in_ready, 1);
        check_val("midrst_out_last", out_last, 0);
        send(8'h10);
        wait_drain(0);

        // Pointer-sensitive pair of batches.
        out_ready = 1'b1;
        send(8'h06);
        wait_drain(0);
        send(8'h09);
        wait_drain(0);

        // Random vectors with random back-pressure.
        for (int n = 0; n < 8; n++) begin
            out_ready = 1'($urandom_range(0, 1));
            send(8'($urandom_range(1, 255)));
            wait_drain(1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pending_encoder8_3.md
Name: pending_encoder8_3

Overview:
- Sequential counterpart to the 3:8 register-select decoder: takes an 8-bit one-hot/multi-hot request vector and emits the index of each set bit, one per handshake, as 3-bit binary codes.
- Used in the CPU to serialise multi-bit selects, such as pending write-back or interrupt lines, into encoded register numbers.
- Valid/ready on both sides.

Parameters:
- WIDTH, 8, request vector width; must equal 2**IDX_W.
- IDX_W, 3, encoded index width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  request vector present.
- in_ready  output  1  block can accept a vector.
- in_req  input  WIDTH  request vector, bit i means index i is pending.
- out_valid  output  1  out_idx holds a valid index.
- out_ready  input  1  consumer takes out_idx this cycle.
- out_idx  output  IDX_W  binary index of the bit currently granted.
- out_last  output  1  out_idx is the final pending bit of the batch.
- busy  output  1  pending register non-zero.

Behaviour:
- Reset values:
  - state=IDLE, pending=0, rr_ptr=0.
  - in_ready=1 (combinational from state).
  - out_valid=0, out_idx=0, out_last=0, busy=0.
- States: IDLE, DRAIN.
- IDLE:
  - in_ready=1, out_valid=0.
  - in_valid=1 with in_req!=0: pending<=in_req, go to DRAIN.
  - in_valid=1 with in_req==0: accepted and dropped, stay in IDLE, no output.
- DRAIN:
  - in_ready=0, out_valid=1.
  - out_idx = lowest set bit of pending (combinational from pending).
  - out_last = 1 iff popcount(pending)==1.
- Latency: vector accepted at edge N -> out_valid=1 in the cycle after N. One index is emitted per out_ready cycle, so a k-bit vector drains in k handshake cycles.
- Handshake on out_valid & out_ready:
  - Clear bit out_idx in pending.
  - If out_last, go to IDLE. in_ready=1 the next cycle, so there is no back-to-back accept in the same cycle.
- out_ready=0: out_idx and out_last hold stable while out_valid=1.
- in_valid is ignored while in DRAIN; in_req is not sampled.
- Reset asserted mid-DRAIN: pending is discarded. The next cycle matches the reset values. No partial output after reset.
- busy = (pending != 0); equal to (state==DRAIN).
- in_req=8'hFF: emits 0..7 in order, with out_last on index 7.

Optional Feature:
- Macro: PENDING_ENC_ROUND_ROBIN_EN.
- Defined:
  - Selection starts at rr_ptr and searches upward, wrapping 7->0.
  - On each handshake, rr_ptr <= out_idx+1 (mod WIDTH).
  - rr_ptr persists across batches; reset sets it to 0.
- Undefined:
  - Strict lowest-index-first.
  - No rr_ptr register exists.

Decomposition:
- Package pending_enc_pkg: WIDTH/IDX_W constants and the state enum (IDLE, DRAIN).
- Sub-module prio_enc8_3 (combinational): lowest-set-bit encoder with found flag. Inputs: 8-bit vector. Outputs: 3-bit index, found.
  - The round-robin variant rotates the vector by rr_ptr, encodes it, then adds rr_ptr back (mod 8).

Test Plan:
- Reset, then in_req=8'b0010_0100 with out_ready=1 -> out_idx 2 (out_last=0), then 5 (out_last=1); in_ready=1 the following cycle.
- in_req=8'hFF with out_ready toggling 1,0,1,... -> indices 0..7 in order; out_idx stable during every out_ready=0 cycle; out_last only on 7.
- in_req=8'h00 with in_valid=1 -> in_ready stays 1, out_valid never asserts, busy=0.
- in_req=8'h81, second in_valid=1 with 8'h02 during DRAIN -> 8'h02 is ignored; outputs are 0, then 7 (out_last); state returns to IDLE.
- in_req=8'h0F, reset after the first handshake -> next cycle out_valid=0, busy=0, in_ready=1; a fresh 8'h10 yields a single index 4 with out_last=1.
- With PENDING_ENC_ROUND_ROBIN_EN: batch 8'h06 emits 1, 2 (rr_ptr=3); next batch 8'h09 emits 3, then 0.
